// File: rtl/traffic_intersection_ctrl.sv
// traffic_intersection_ctrl: fixed-time intersection sequencer with emergency preemption.
// Define PED_REQ_EN to add a pedestrian walk phase (ped_req/walk ports, PED_TICKS parameter).
module traffic_intersection_ctrl #(
    parameter int NUM_DIR      = 2,
    parameter int GREEN_TICKS  = 4,
    parameter int YELLOW_TICKS = 2,
    parameter int ALLRED_TICKS = 1,
    parameter int CNT_W        = 8
`ifdef PED_REQ_EN
    ,
    parameter int PED_TICKS    = 3
`endif
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               emergency,
    input  logic [1:0]         emerg_dir,
    output logic [NUM_DIR-1:0] red,
    output logic [NUM_DIR-1:0] yellow,
    output logic [NUM_DIR-1:0] green,
    output logic [1:0]         cur_dir,
    output logic [2:0]         phase
`ifdef PED_REQ_EN
    ,
    input  logic               ped_req,
    output logic               walk
`endif
);
    typedef enum logic [2:0] {
        ALL_RED = 3'd0,
        GREEN   = 3'd1,
        YELLOW  = 3'd2,
        EMERG   = 3'd3,
        PED     = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] G_LD = CNT_W'(GREEN_TICKS - 1);
    localparam logic [CNT_W-1:0] Y_LD = CNT_W'(YELLOW_TICKS - 1);
    localparam logic [CNT_W-1:0] A_LD = CNT_W'(ALLRED_TICKS - 1);
    localparam logic [1:0]       LAST = 2'(NUM_DIR - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         dir_q, dir_d, dir_nxt, ed;
    logic [NUM_DIR-1:0] red_q, red_d, yellow_q, yellow_d, green_q, green_d, one_hot;
    logic               zero;
`ifdef PED_REQ_EN
    localparam logic [CNT_W-1:0] P_LD = CNT_W'(PED_TICKS - 1);
    logic pend_q, pend_d, walk_q, walk_d;
`endif

    always_comb begin
        zero     = cnt_q == '0;
        ed       = ({1'b0, emerg_dir} >= 3'(NUM_DIR)) ? 2'd0 : emerg_dir;
        dir_nxt  = (dir_q == LAST) ? 2'd0 : dir_q + 2'd1;
        state_d  = state_q;
        cnt_d    = cnt_q - CNT_W'(1);
        dir_d    = dir_q;
`ifdef PED_REQ_EN
        pend_d   = pend_q | ped_req;
`endif
        case (state_q)
            ALL_RED: if (zero) begin
                if (emergency) begin
                    state_d = EMERG;
                    dir_d   = ed;
                    cnt_d   = cnt_q;
                end
`ifdef PED_REQ_EN
                else if (pend_q) begin
                    state_d = PED;
                    cnt_d   = P_LD;
                    pend_d  = ped_req;
                end
`endif
                else begin
                    state_d = GREEN;
                    dir_d   = dir_nxt;
                    cnt_d   = G_LD;
                end
            end
            // Preemption for another direction cuts green short but still runs a full yellow.
            GREEN: if (emergency && dir_q == ed) begin
                state_d = EMERG;
                cnt_d   = cnt_q;
            end else if (emergency || zero) begin
                state_d = YELLOW;
                cnt_d   = Y_LD;
            end
            YELLOW: if (zero) begin
                state_d = ALL_RED;
                cnt_d   = A_LD;
            end
            EMERG: begin
                cnt_d = cnt_q;
                if (!emergency) begin
                    state_d = YELLOW;
                    cnt_d   = Y_LD;
                end
            end
`ifdef PED_REQ_EN
            PED: if (zero) begin
                if (emergency) begin
                    state_d = EMERG;
                    dir_d   = ed;
                    cnt_d   = cnt_q;
                end else begin
                    state_d = GREEN;
                    dir_d   = dir_nxt;
                    cnt_d   = G_LD;
                end
            end
`endif
            default: begin
                state_d = ALL_RED;
                cnt_d   = A_LD;
            end
        endcase
        one_hot  = NUM_DIR'(1) << dir_d;
        green_d  = (state_d == GREEN || state_d == EMERG) ? one_hot : '0;
        yellow_d = (state_d == YELLOW) ? one_hot : '0;
        red_d    = ~(green_d | yellow_d);
`ifdef PED_REQ_EN
        walk_d   = state_d == PED;
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= ALL_RED;
            cnt_q    <= A_LD;
            dir_q    <= LAST;
            red_q    <= '1;
            yellow_q <= '0;
            green_q  <= '0;
`ifdef PED_REQ_EN
            pend_q   <= 1'b0;
            walk_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dir_q    <= dir_d;
            red_q    <= red_d;
            yellow_q <= yellow_d;
            green_q  <= green_d;
`ifdef PED_REQ_EN
            pend_q   <= pend_d;
            walk_q   <= walk_d;
`endif
        end
    end

    assign red     = red_q;
    assign yellow  = yellow_q;
    assign green   = green_q;
    assign cur_dir = dir_q;
    assign phase   = state_q;
`ifdef PED_REQ_EN
    assign walk    = walk_q;
`endif
endmodule
